// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall, branch flush and interrupt drain controller (optional forwarding: PIPELINE_HAZARD_FWD_EN)
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_uses_x,
    input  logic        id_uses_y,
    input  logic [4:0]  id_rs_x,
    input  logic [4:0]  id_rs_y,
    input  logic        ex_valid,
    input  logic        ex_rf_wr,
    input  logic [4:0]  ex_wb_addr,
    input  logic        ex_mem_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_valid,
    input  logic        mem_rf_wr,
    input  logic [4:0]  mem_wb_addr,
    input  logic        int_req,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_nop,
    output logic        idex_nop,
    output logic        int_ack,
    output logic [1:0]  fwd_x_sel,
    output logic [1:0]  fwd_y_sel,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

    state_t state;

    logic hx_ex, hx_mem, hy_ex, hy_mem;
    logic haz;
    logic count_hazard;

    // WB never matches: the register file is write-first
    assign hx_ex  = id_valid & id_uses_x & ex_valid  & ex_rf_wr  & (id_rs_x == ex_wb_addr);
    assign hx_mem = id_valid & id_uses_x & mem_valid & mem_rf_wr & (id_rs_x == mem_wb_addr);
    assign hy_ex  = id_valid & id_uses_y & ex_valid  & ex_rf_wr  & (id_rs_y == ex_wb_addr);
    assign hy_mem = id_valid & id_uses_y & mem_valid & mem_rf_wr & (id_rs_y == mem_wb_addr);

`ifdef PIPELINE_HAZARD_FWD_EN
    // only a scratch-RAM load in EX is too late to forward
    assign haz = ex_mem_rd & (hx_ex | hy_ex);

    // operand bypass select, EX result has priority over MEM result
    always_comb begin
        fwd_x_sel = 2'd0;
        fwd_y_sel = 2'd0;
        if (!rst && !ex_branch_taken) begin
            if (hx_ex)
                fwd_x_sel = 2'd1;
            else if (hx_mem)
                fwd_x_sel = 2'd2;
            if (hy_ex)
                fwd_y_sel = 2'd1;
            else if (hy_mem)
                fwd_y_sel = 2'd2;
        end
    end
`else
    logic unused_mem_rd;

    assign haz           = hx_ex | hx_mem | hy_ex | hy_mem;
    assign fwd_x_sel     = 2'd0;
    assign fwd_y_sel     = 2'd0;
    assign unused_mem_rd = ex_mem_rd;
`endif

    // stall cycles are counted only for a real hazard stall in RUN
    assign count_hazard = ~rst & (state == RUN) & ~ex_branch_taken & haz;

    // pipeline register controls from current state and stage inputs
    always_comb begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_nop   = 1'b0;
        idex_nop   = 1'b0;
        int_ack    = 1'b0;
        if (rst) begin
            pc_stall = 1'b1;
            ifid_nop = 1'b1;
            idex_nop = 1'b1;
        end else begin
            int_ack = (state == ACK);
            if (ex_branch_taken) begin
                // flush wins: the instruction that would stall is discarded
                ifid_nop = 1'b1;
                idex_nop = 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (haz) begin
                            pc_stall   = 1'b1;
                            ifid_stall = 1'b1;
                            idex_nop   = 1'b1;
                        end
                    end
                    DRAIN: begin
                        pc_stall = 1'b1;
                        ifid_nop = 1'b1;
                    end
                    ACK: begin
                        ifid_nop = 1'b1;
                    end
                    default: begin
                        pc_stall = 1'b0;
                    end
                endcase
            end
        end
    end

    // interrupt entry sequencing and hazard-stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= 16'd0;
        end else begin
            if (count_hazard)
                stall_cnt <= stall_cnt + 16'd1;
            case (state)
                RUN: begin
                    if (int_req && !ex_branch_taken && !haz)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!ex_valid && !mem_valid && !ex_branch_taken)
                        state <= ACK;
                end
                ACK: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic       wr;
        logic [4:0] wb;
        logic       ux;
        logic [4:0] rx;
        logic       uy;
        logic [4:0] ry;
        logic       mrd;
        logic       br;
    } ins_t;

    typedef struct {
        string       tag;
        logic        ps;
        logic        fs;
        logic        fn;
        logic        en;
        logic        ack;
        logic [1:0]  fx;
        logic [1:0]  fy;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid, id_uses_x, id_uses_y;
    logic [4:0]  id_rs_x, id_rs_y;
    logic        ex_valid, ex_rf_wr, ex_mem_rd, ex_branch_taken;
    logic [4:0]  ex_wb_addr;
    logic        mem_valid, mem_rf_wr;
    logic [4:0]  mem_wb_addr;
    logic        int_req;
    logic        pc_stall, ifid_stall, ifid_nop, idex_nop, int_ack;
    logic [1:0]  fwd_x_sel, fwd_y_sel;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // reference model: pipeline slot contents, interrupt phase, counter
    ins_t        s_id, s_ex, s_mem;
    ins_t        fetch_q[$];
    int          phase;     // 0 running, 1 draining, 2 acknowledging
    logic [15:0] m_cnt;
    bit          freeze;
    string       tag;

    pipeline_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_uses_x       (id_uses_x),
        .id_uses_y       (id_uses_y),
        .id_rs_x         (id_rs_x),
        .id_rs_y         (id_rs_y),
        .ex_valid        (ex_valid),
        .ex_rf_wr        (ex_rf_wr),
        .ex_wb_addr      (ex_wb_addr),
        .ex_mem_rd       (ex_mem_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_valid       (mem_valid),
        .mem_rf_wr       (mem_rf_wr),
        .mem_wb_addr     (mem_wb_addr),
        .int_req         (int_req),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_nop        (ifid_nop),
        .idex_nop        (idex_nop),
        .int_ack         (int_ack),
        .fwd_x_sel       (fwd_x_sel),
        .fwd_y_sel       (fwd_y_sel),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic ins_t rand_ins();
        ins_t i;
        i.v   = ($urandom_range(0, 3) != 0);
        i.wr  = 1'($urandom_range(0, 1));
        i.wb  = 5'($urandom_range(0, 3));
        i.ux  = 1'($urandom_range(0, 1));
        i.rx  = 5'($urandom_range(0, 3));
        i.uy  = 1'($urandom_range(0, 1));
        i.ry  = 5'($urandom_range(0, 3));
        i.mrd = 1'($urandom_range(0, 1));
        i.br  = i.v & ($urandom_range(0, 7) == 0);
        return i;
    endfunction

    function automatic ins_t mk(input bit v, input bit wr, input int wb, input bit ux, input int rx,
                                input bit uy, input int ry, input bit mrd, input bit br);
        ins_t i;
        i.v = v; i.wr = wr; i.wb = 5'(wb); i.ux = ux; i.rx = 5'(rx);
        i.uy = uy; i.ry = 5'(ry); i.mrd = mrd; i.br = br;
        return i;
    endfunction

    function automatic bit reads(input bit u, input logic [4:0] r, input ins_t w);
        return s_id.v && u && w.v && w.wr && (r == w.wb);
    endfunction

    // expected outputs for the current slots, straight from the rules
    task automatic model_eval(input bit r, output exp_t e, output bit need);
        bit mx_ex, mx_mem, my_ex, my_mem;
        mx_ex  = reads(s_id.ux, s_id.rx, s_ex);
        mx_mem = reads(s_id.ux, s_id.rx, s_mem);
        my_ex  = reads(s_id.uy, s_id.ry, s_ex);
        my_mem = reads(s_id.uy, s_id.ry, s_mem);
`ifdef PIPELINE_HAZARD_FWD_EN
        need = s_ex.mrd && (mx_ex || my_ex);
`else
        need = mx_ex || mx_mem || my_ex || my_mem;
`endif
        e.tag = tag; e.cnt = m_cnt;
        e.ps = 0; e.fs = 0; e.fn = 0; e.en = 0; e.ack = 0; e.fx = 0; e.fy = 0;
        if (r) begin
            e.ps = 1; e.fn = 1; e.en = 1;
            return;
        end
        if (s_ex.br) begin
            e.fn = 1; e.en = 1;
        end else if (phase == 0 && need) begin
            e.ps = 1; e.fs = 1; e.en = 1;
        end else if (phase == 1) begin
            e.ps = 1; e.fn = 1;
        end else if (phase == 2) begin
            e.fn = 1;
        end
        e.ack = (phase == 2);
`ifdef PIPELINE_HAZARD_FWD_EN
        if (!s_ex.br) begin
            e.fx = mx_ex ? 2'd1 : (mx_mem ? 2'd2 : 2'd0);
            e.fy = my_ex ? 2'd1 : (my_mem ? 2'd2 : 2'd0);
        end
`endif
    endtask

    // advance the model across one clock edge using the expected controls
    task automatic model_step(input bit r, input bit irq, input exp_t e, input bit need);
        ins_t nxt_id;
        if (r) begin
            phase = 0;
            m_cnt = 16'd0;
        end else begin
            if (phase == 0 && !s_ex.br && need)
                m_cnt = m_cnt + 16'd1;
            if (phase == 0) begin
                if (irq && !s_ex.br && !need) phase = 1;
            end else if (phase == 1) begin
                if (!s_ex.v && !s_mem.v && !s_ex.br) phase = 2;
            end else begin
                phase = 0;
            end
        end
        if (!freeze) begin
            if (e.fn)
                nxt_id = '0;
            else if (e.fs)
                nxt_id = s_id;
            else if (fetch_q.size() > 0)
                nxt_id = fetch_q.pop_front();
            else
                nxt_id = '0;
            s_mem = s_ex;
            s_ex  = e.en ? ins_t'('0) : s_id;
            s_id  = nxt_id;
        end
    endtask

    task automatic step(input bit r, input bit irq);
        exp_t e;
        bit   need;
        rst = r; int_req = irq;
        id_valid = s_id.v; id_uses_x = s_id.ux; id_uses_y = s_id.uy;
        id_rs_x = s_id.rx; id_rs_y = s_id.ry;
        ex_valid = s_ex.v; ex_rf_wr = s_ex.wr; ex_wb_addr = s_ex.wb;
        ex_mem_rd = s_ex.mrd; ex_branch_taken = s_ex.br;
        mem_valid = s_mem.v; mem_rf_wr = s_mem.wr; mem_wb_addr = s_mem.wb;
        model_eval(r, e, need);
        exp_q.push_back(e);
        @(posedge clk);
        model_step(r, irq, e, need);
        #1;
    endtask

    task automatic chk(input string t, input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s %s actual=%0d required=%0d", t, name, act, req);
        end
    endtask

    // monitor: every cycle presents outputs, compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "pc_stall",   int'(pc_stall),   int'(e.ps));
                chk(e.tag, "ifid_stall", int'(ifid_stall), int'(e.fs));
                chk(e.tag, "ifid_nop",   int'(ifid_nop),   int'(e.fn));
                chk(e.tag, "idex_nop",   int'(idex_nop),   int'(e.en));
                chk(e.tag, "int_ack",    int'(int_ack),    int'(e.ack));
                chk(e.tag, "fwd_x_sel",  int'(fwd_x_sel),  int'(e.fx));
                chk(e.tag, "fwd_y_sel",  int'(fwd_y_sel),  int'(e.fy));
                chk(e.tag, "stall_cnt",  int'(stall_cnt),  int'(e.cnt));
            end
        end
    end

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        phase = 0; m_cnt = 16'd0; freeze = 1;
        s_id = '0; s_ex = '0; s_mem = '0;
        int_req = 0;
        @(posedge clk); #1;

        tag = "reset";
        for (int k = 0; k < 2; k++) begin
            s_id = rand_ins(); s_ex = rand_ins(); s_mem = rand_ins();
            step(1, 1'($urandom_range(0, 1)));
        end
        tag = "after_reset";
        s_id = '0; s_ex = '0; s_mem = '0;
        step(0, 0);

        tag = "raw_stall";
        freeze = 0;
        s_id  = mk(1, 0, 0, 1, 5, 0, 0, 0, 0);
        s_ex  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0);
        s_mem = '0;
        repeat (4) step(0, 0);

        tag = "load_use";
        s_id  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0);
        s_ex  = mk(1, 1, 3, 0, 0, 0, 0, 1, 0);
        s_mem = mk(1, 1, 3, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0);

        tag = "branch_vs_hazard";
        s_id  = mk(1, 0, 0, 1, 7, 0, 0, 0, 0);
        s_ex  = mk(1, 1, 7, 0, 0, 0, 0, 0, 1);
        s_mem = '0;
        repeat (3) step(0, 0);

        tag = "int_drain";
        s_id  = '0;
        s_ex  = mk(1, 1, 9, 0, 0, 0, 0, 0, 0);
        s_mem = mk(1, 1, 10, 0, 0, 0, 0, 0, 0);
        step(0, 1);
        repeat (5) step(0, 0);

        tag = "int_drain_reset";
        s_id  = '0;
        s_ex  = mk(1, 1, 9, 0, 0, 0, 0, 0, 0);
        s_mem = mk(1, 1, 10, 0, 0, 0, 0, 0, 0);
        step(0, 1);
        step(0, 0);
        step(1, 0);
        repeat (3) step(0, 0);

        tag = "int_empty";
        s_id = '0; s_ex = '0; s_mem = '0;
        step(0, 1);
        repeat (3) step(0, 0);

        tag = "random_pipe";
        for (int k = 0; k < 3000; k++) begin
            if (fetch_q.size() < 4)
                fetch_q.push_back(rand_ins());
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) == 0));
        end

        tag = "random_raw";
        freeze = 1;
        for (int k = 0; k < 1000; k++) begin
            s_id = rand_ins(); s_ex = rand_ins(); s_mem = rand_ins();
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
        end

        tag = "counter_wrap";
        s_id = '0; s_ex = '0; s_mem = '0;
        step(1, 0);
        s_id  = mk(1, 0, 0, 1, 1, 0, 0, 0, 0);
        s_ex  = mk(1, 1, 1, 0, 0, 0, 0, 1, 0);
        s_mem = '0;
        for (int k = 0; k < 65537; k++)
            step(0, 0);
        s_id = '0; s_ex = '0;
        step(0, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_scoreboard actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
